hex_msg_scroller: RTL and testbench
===================================

// Module: hex_msg_scroller
// PURPOSE
//  Parametrised scrolling-message driver for the board's 7-segment bank. A prescaler on CLOCK_50
//  paces a rotating window of NUM_DIGITS glyphs over a loadable message of MSG_LEN glyphs.
//  Adds direction, run/step control, message load and a wrap pulse.
//  Sits between board switches/keys and the HEX outputs, replacing fixed per-display decoders.
// PARAMETERS
//  TICK_DIV    50_000_000  CLOCK_50 cycles per scroll step (>=2); 1 s at 50 MHz
//  NUM_DIGITS  4           number of 7-seg displays driven (1..8)
//  MSG_LEN     8           message length in glyphs (2..32); MSG_LEN < NUM_DIGITS is legal
//  PAUSE_TICKS 3           extra hold ticks at offset 0 (used only with HEX_SCROLL_PAUSE_EN)
// PORTS
//  CLOCK_50  in   1             system clock, all logic on rising edge
//  resetn    in   1             synchronous reset, active-low
//  msg       in   5*MSG_LEN     glyph codes, glyph j = msg[5j+4:5j]; j=0 is first character
//  load      in   1             1-cycle pulse: capture msg into internal buffer
//  run       in   1             1 = advance on every prescaler tick
//  step      in   1             1-cycle pulse: advance once (honoured only when run=0)
//  dir       in   1             1 = scroll left (offset+1), 0 = scroll right (offset-1)
//  hex       out  7*NUM_DIGITS  active-low segments; digit k = hex[7k+6:7k], digit 0 rightmost; bit0=a..bit6=g
//  offset    out  clog2(MSG_LEN) current window start index
//  wrap      out  1             1-cycle pulse when offset transitions to 0 by an advance
// BEHAVIOUR
//  Reset (resetn=0 at edge): prescaler=0, offset=0, buffer=all 16 (blank), wrap=0, hex=all 1s.
//  Prescaler: counts 0..TICK_DIV-1 always (free-running, independent of run); tick=1 for the one
//   cycle count==TICK_DIV-1, then count returns to 0.
//  Advance condition adv = (run & tick) | (~run & step); tick and step together with run=1 -> one advance.
//  Advance: dir=1 offset<=(offset==MSG_LEN-1)?0:offset+1; dir=0 offset<=(offset==0)?MSG_LEN-1:offset-1.
//  wrap asserted in the cycle after an advance that made offset 0 from non-zero (both directions).
//  load: buffer<=msg, offset<=0, prescaler<=0; load has priority over adv in the same cycle; no wrap pulse.
//  Display: digit k shows buffer[(offset + NUM_DIGITS-1-k) mod MSG_LEN]; leftmost digit = glyph at offset.
//  hex is registered: reflects offset/buffer of the previous cycle (1-cycle latency after any update).
//  Glyph codes: 0-15 hex digits 0-F (b,d lowercase); 16 blank; 17 H; 18 L; 19 P; 20 U; 21 r; 22 n;
//   23 '-' (g only); 24-31 blank. Lit segment = 0.
//  dir may change any cycle; takes effect on the next advance. step ignored while run=1 except as above.
//  Reset mid-scroll: all state returns to reset values on the same edge; message must be reloaded.
// CONFIGURATION
//  HEX_SCROLL_PAUSE_EN defined: when an advance lands on offset 0, the next PAUSE_TICKS ticks are
//   consumed without advancing (hold counter, cleared by reset/load); step while run=0 bypasses the hold
//   and clears it. wrap pulse unchanged.
//  Not defined: no hold counter; every qualifying tick advances; PAUSE_TICKS unused.
// TESTING  (TICK_DIV=4, NUM_DIGITS=4, MSG_LEN=8 unless stated)
//  Reset: resetn=0 2 cycles -> hex=28'hFFFFFFF, offset=0, wrap=0; release -> hex stays blank (buffer blank).
//  Load "HELLO---"(17,14,18,18,0,23,23,23), run=1, dir=1 -> next cycle digits3..0 = H,E,L,L; offset
//   steps 0,1,2.. every 4 cycles; after 8 ticks offset 7->0 with one wrap pulse.
//  dir=0 from offset 0 -> next tick offset=7, digits3..0 = '-',H,E,L; wrap pulses on 1->0 only.
//  run=0: ticks ignored; step pulse -> offset+1 exactly once; step coincident with load -> offset=0.
//  MSG_LEN=2 with NUM_DIGITS=4, msg (1,2) -> digits3..0 = 1,2,1,2; after advance 2,1,2,1.
//  HEX_SCROLL_PAUSE_EN, PAUSE_TICKS=3: after reaching offset 0, offset holds for 3 ticks, moves to 1 on
//   the 4th; without macro it moves on the 1st.

Source files
------------

// File: rtl/hex_msg_scroller.sv
// hex_msg_scroller: scrolls a window of NUM_DIGITS glyphs across a loadable
// MSG_LEN-glyph message on active-low 7-segment displays. A free-running
// prescaler paces the scroll. Each scroll step is an "advance", which can come
// from a prescaler tick while running or from a single step pulse while stopped.
// Optional feature macro: HEX_SCROLL_PAUSE_EN. When it is defined, the scroller
// holds on offset 0 for PAUSE_TICKS ticks.
module hex_msg_scroller #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_LEN     = 8,
    parameter int PAUSE_TICKS = 3
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic [5*MSG_LEN-1:0]         msg,
    input  logic                         load,
    input  logic                         run,
    input  logic                         step,
    input  logic                         dir,
    output logic [7*NUM_DIGITS-1:0]      hex,
    output logic [$clog2(MSG_LEN)-1:0]   offset,
    output logic                         wrap
);

    localparam int OFF_W = $clog2(MSG_LEN);
    localparam int PW    = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    LAST_CNT = PW'(TICK_DIV - 1);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(MSG_LEN - 1);

    logic [PW-1:0]             r_presc;
    logic [OFF_W-1:0]          r_offset;
    logic [5*MSG_LEN-1:0]      r_buf;
    logic                      r_wrap;
    logic [7*NUM_DIGITS-1:0]   r_hex;

    logic                      w_tick;
    logic                      w_adv;
    logic [OFF_W-1:0]          w_off_nxt;
    logic [7*NUM_DIGITS-1:0]   w_hex_nxt;

    // Glyph code to active-low segments (bit0=a .. bit6=g, lit = 0).
    function automatic logic [6:0] seg_decode(input logic [4:0] g);
        logic [6:0] on;
        case (g)
            5'd0:  on = 7'h3F;
            5'd1:  on = 7'h06;
            5'd2:  on = 7'h5B;
            5'd3:  on = 7'h4F;
            5'd4:  on = 7'h66;
            5'd5:  on = 7'h6D;
            5'd6:  on = 7'h7D;
            5'd7:  on = 7'h07;
            5'd8:  on = 7'h7F;
            5'd9:  on = 7'h6F;
            5'd10: on = 7'h77;
            5'd11: on = 7'h7C;
            5'd12: on = 7'h39;
            5'd13: on = 7'h5E;
            5'd14: on = 7'h79;
            5'd15: on = 7'h71;
            5'd17: on = 7'h76;
            5'd18: on = 7'h38;
            5'd19: on = 7'h73;
            5'd20: on = 7'h3E;
            5'd21: on = 7'h50;
            5'd22: on = 7'h54;
            5'd23: on = 7'h40;
            default: on = 7'h00;
        endcase
        return ~on;
    endfunction

    assign w_tick = (r_presc == LAST_CNT);

`ifdef HEX_SCROLL_PAUSE_EN
    localparam int HW = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1;
    logic [HW-1:0] r_hold;
    logic          w_hold_eat;

    // A running tick is swallowed while the hold counter is non-zero.
    assign w_hold_eat = run & w_tick & (r_hold != '0);
    assign w_adv      = (run & w_tick & ~w_hold_eat) | (~run & step);

    // Hold counter: armed when an advance lands on 0, drained by running ticks, cleared by a manual step.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn || load) begin
            r_hold <= '0;
        end else if (w_adv && (w_off_nxt == '0)) begin
            r_hold <= HW'(PAUSE_TICKS);
        end else if (!run && step) begin
            r_hold <= '0;
        end else if (w_hold_eat) begin
            r_hold <= r_hold - HW'(1);
        end
    end
`else
    assign w_adv = (run & w_tick) | (~run & step);
`endif

    // Next window start for one advance in the requested direction, with wrap-around.
    always_comb begin
        w_off_nxt = r_offset;
        if (dir) begin
            w_off_nxt = (r_offset == LAST_OFF) ? '0 : r_offset + OFF_W'(1);
        end else begin
            w_off_nxt = (r_offset == '0) ? LAST_OFF : r_offset - OFF_W'(1);
        end
    end

    // Display image: the leftmost digit shows the glyph at the offset, and the digits to its right follow in message order.
    always_comb begin
        w_hex_nxt = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_hex_nxt[7*k +: 7] =
                seg_decode(r_buf[5*((int'(r_offset) + NUM_DIGITS - 1 - k) % MSG_LEN) +: 5]);
        end
    end

    // Main state: prescaler, message buffer, offset, wrap pulse and registered display.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_presc  <= '0;
            r_offset <= '0;
            r_buf    <= {MSG_LEN{5'd16}};
            r_wrap   <= 1'b0;
            r_hex    <= '1;
        end else begin
            r_hex  <= w_hex_nxt;
            r_wrap <= 1'b0;
            if (load) begin
                // Load wins over any advance in the same cycle and never produces a wrap pulse.
                r_buf    <= msg;
                r_offset <= '0;
                r_presc  <= '0;
            end else begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
                if (w_adv) begin
                    r_offset <= w_off_nxt;
                    r_wrap   <= (w_off_nxt == '0) && (r_offset != '0);
                end
            end
        end
    end

    assign hex    = r_hex;
    assign offset = r_offset;
    assign wrap   = r_wrap;

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Bench for hex_msg_scroller. It runs a main instance (TICK_DIV=4, 4 digits,
// 8 glyphs) and a second instance with a 2-glyph message.
module tb_hex_msg_scroller;

  localparam int TD = 4;
  localparam int ND = 4;
  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [39:0] msg;
  logic        load, run, step, dir;
  logic [27:0] hex;
  logic [2:0]  offset;
  logic        wrap;

  logic [9:0]  msg2;
  logic        load2, step2;
  logic [27:0] hex2;
  logic [0:0]  offset2;
  logic        wrap2;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  int          m_presc, m_off, m_hold;
  logic [39:0] m_buf;

  typedef struct {
    logic [39:0] msg;
    logic [27:0] exp;
  } vec_t;
  vec_t vecs[5];

  hex_msg_scroller #(.TICK_DIV(TD), .NUM_DIGITS(ND), .MSG_LEN(ML), .PAUSE_TICKS(3)) dut (
    .CLOCK_50(clk), .resetn(resetn), .msg(msg), .load(load), .run(run),
    .step(step), .dir(dir), .hex(hex), .offset(offset), .wrap(wrap)
  );

  hex_msg_scroller #(.TICK_DIV(TD), .NUM_DIGITS(4), .MSG_LEN(2), .PAUSE_TICKS(3)) dut2 (
    .CLOCK_50(clk), .resetn(resetn), .msg(msg2), .load(load2), .run(1'b0),
    .step(step2), .dir(1'b1), .hex(hex2), .offset(offset2), .wrap(wrap2)
  );

  always #10 clk = ~clk;

  function automatic logic [6:0] seg(input int g);
    logic [6:0] on;
    case (g)
      0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
      4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
      8: on = 7'h7F;  9: on = 7'h6F;  10: on = 7'h77; 11: on = 7'h7C;
      12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; 15: on = 7'h71;
      17: on = 7'h76; 18: on = 7'h38; 19: on = 7'h73; 20: on = 7'h3E;
      21: on = 7'h50; 22: on = 7'h54; 23: on = 7'h40;
      default: on = 7'h00;
    endcase
    return ~on;
  endfunction

  function automatic logic [27:0] digits(input int d3, input int d2, input int d1, input int d0);
    return {seg(d3), seg(d2), seg(d1), seg(d0)};
  endfunction

  function automatic logic [39:0] pk(input int a0, input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6, input int a7);
    return {5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [27:0] disp(input logic [39:0] b, input int off);
    logic [27:0] h;
    for (int k = 0; k < ND; k++) h[7*k +: 7] = seg(int'(b[5*((off + ND - 1 - k) % ML) +: 5]));
    return h;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic model_reset();
    m_buf = {8{5'd16}};
    m_off = 0; m_presc = 0; m_hold = 0;
  endtask

  // Drive one cycle on the main instance, predict it, then compare after the edge.
  task automatic cyc(input logic l, input logic r, input logic s, input logic d, input logic [39:0] m);
    logic tick, adv, eat, w;
    int nxt;
    logic [27:0] h;
    load = l; run = r; step = s; dir = d; msg = m;
    h = disp(m_buf, m_off);
    w = 1'b0;
    if (l) begin
      m_buf = m; m_off = 0; m_presc = 0; m_hold = 0;
    end else begin
      tick = (m_presc == TD - 1);
      m_presc = tick ? 0 : m_presc + 1;
      eat = 1'b0;
`ifdef HEX_SCROLL_PAUSE_EN
      eat = r && tick && (m_hold > 0);
`endif
      adv = (r && tick && !eat) || (!r && s);
      nxt = d ? (m_off + 1) % ML : (m_off + ML - 1) % ML;
`ifdef HEX_SCROLL_PAUSE_EN
      if (adv && nxt == 0) m_hold = 3;
      else if (!r && s) m_hold = 0;
      else if (eat) m_hold = m_hold - 1;
`endif
      if (adv) begin
        w = (nxt == 0) && (m_off != 0);
        m_off = nxt;
      end
    end
    exp_q.push_back({h, 3'(m_off), w});
    @(posedge clk); #1;
    chk("cycle {hex,offset,wrap}", {hex, offset, wrap}, exp_q.pop_front());
  endtask

  logic [39:0] hello;
  int wraps, cnt;
  bit found;

  initial begin
    resetn = 1'b0; load = 0; run = 0; step = 0; dir = 1; msg = '0;
    msg2 = '0; load2 = 0; step2 = 0;
    hello = pk(17, 14, 18, 18, 0, 23, 23, 23);

    vecs[0] = '{pk(0, 1, 2, 3, 4, 5, 6, 7),         digits(0, 1, 2, 3)};
    vecs[1] = '{pk(8, 9, 10, 11, 12, 13, 14, 15),   digits(8, 9, 10, 11)};
    vecs[2] = '{pk(12, 13, 14, 15, 0, 0, 0, 0),     digits(12, 13, 14, 15)};
    vecs[3] = '{pk(17, 18, 19, 20, 21, 22, 23, 16), digits(17, 18, 19, 20)};
    vecs[4] = '{pk(21, 22, 23, 24, 31, 16, 5, 9),   digits(21, 22, 23, 31)};

    // Reset held for two cycles.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset hex", 32'(hex), 32'h0FFFFFFF);
    chk("reset offset", 32'(offset), 32'd0);
    chk("reset wrap", 32'(wrap), 32'd0);
    chk("reset hex2", 32'(hex2), 32'h0FFFFFFF);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, '0);
    chk("blank after release", 32'(hex), 32'h0FFFFFFF);

    // Decoder table: load, then the display shows glyphs 0..3 one cycle later.
    foreach (vecs[i]) begin
      cyc(1, 0, 0, 1, vecs[i].msg);
      cyc(0, 0, 0, 1, vecs[i].msg);
      chk($sformatf("table hex %0d", i), 32'(hex), 32'(vecs[i].exp));
    end

    // HELLO--- scrolling left.
    cyc(1, 1, 0, 1, hello);
    cyc(0, 1, 0, 1, hello);
    chk("hello first window", 32'(hex), 32'(digits(17, 14, 18, 18)));
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 0, 1, hello);
      if (wrap) wraps++;
    end
    chk("left wrap count", 32'(wraps), 32'd1);
    chk("left offset back to 0", 32'(offset), 32'd0);

    // Reverse from offset 0.
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, hello);
    chk("right 0->7 offset", 32'(offset), 32'd7);
    chk("right 0->7 no wrap", 32'(wrap), 32'd0);
    cyc(0, 1, 0, 0, hello);
    chk("right window", 32'(hex), 32'(digits(23, 17, 14, 18)));
    wraps = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(0, 1, 0, 0, hello);
      if (wrap) wraps++;
    end
    chk("right wrap count", 32'(wraps), 32'd1);
    chk("right offset at 0", 32'(offset), 32'd0);

    // Stopped: ticks ignored, one step gives one advance.
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, hello);
    chk("stopped holds", 32'(offset), 32'd0);
    cyc(0, 0, 1, 1, hello);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, hello);
    chk("single step", 32'(offset), 32'd1);
    cyc(1, 0, 1, 1, hello);
    chk("step with load", 32'(offset), 32'd0);

    // Arrive at 0 via 7->0 while running, then time the move to 1.
    cyc(1, 1, 0, 0, hello);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(0, 1, 0, 0, hello);
      if (offset == 3'd7) found = 1;
    end
    chk("reach 7 in time", 32'(found), 32'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc(0, 1, 0, 1, hello);
      if (wrap) found = 1;
    end
    chk("wrap 7->0 seen", 32'(found), 32'd1);
    cnt = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc(0, 1, 0, 1, hello);
      cnt++;
      if (offset == 3'd1) found = 1;
    end
    chk("left 0->1 reached", 32'(found), 32'd1);
`ifdef HEX_SCROLL_PAUSE_EN
    chk("cycles to leave 0", 32'(cnt), 32'd16);
`else
    chk("cycles to leave 0", 32'(cnt), 32'd4);
`endif

    // Two-glyph message on four digits.
    msg2 = {5'd2, 5'd1};
    load2 = 1;
    cyc(0, 0, 0, 1, hello);
    load2 = 0;
    cyc(0, 0, 0, 1, hello);
    chk("short msg window", 32'(hex2), 32'(digits(1, 2, 1, 2)));
    chk("short msg offset", 32'(offset2), 32'd0);
    step2 = 1;
    cyc(0, 0, 0, 1, hello);
    step2 = 0;
    cyc(0, 0, 0, 1, hello);
    chk("short msg offset 1", 32'(offset2), 32'd1);
    chk("short msg shifted", 32'(hex2), 32'(digits(2, 1, 2, 1)));
    step2 = 1;
    cyc(0, 0, 0, 1, hello);
    step2 = 0;
    chk("short msg wrap", 32'({offset2, wrap2}), 32'b01);

    // Reset in the middle of a scroll.
    cyc(1, 1, 0, 1, hello);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0, 1, hello);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("mid reset hex", 32'(hex), 32'h0FFFFFFF);
    chk("mid reset offset", 32'(offset), 32'd0);
    resetn = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
